// File: rtl/afifo.sv
// afifo: single-clock FIFO with registered empty/full flags and first-word fall-through read data
module afifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_inc,
  input  logic             rd_inc,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_empty,
  output logic             wr_full
);
  logic [DSIZE-1:0] mem [2**ASIZE];
  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             wr_en, rd_en;
  always_comb begin
    wr_en   = wr_inc & ~full_q;
    rd_en   = rd_inc & ~empty_q;
    wptr_d  = wptr_q + {{ASIZE{1'b0}}, wr_en};
    rptr_d  = rptr_q + {{ASIZE{1'b0}}, rd_en};
    empty_d = wptr_d == rptr_d;
    full_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) && (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wptr_q[ASIZE-1:0]] <= wr_data;
  end
  assign rd_data  = mem[rptr_q[ASIZE-1:0]];
  assign rd_empty = empty_q;
  assign wr_full  = full_q;
endmodule

// File: tb/tb_afifo.sv
// tb_afifo: directed stimulus against a queue model of an 8-deep FIFO, checked every negedge
module tb_afifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_inc, rd_inc;
  logic [7:0] rd_data;
  logic       rd_empty, wr_full;
  int         total = 0, bad = 0;
  logic [7:0] q[$];
  afifo #(.DSIZE(8), .ASIZE(3)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc),
    .rd_data(rd_data), .rd_empty(rd_empty), .wr_full(wr_full)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst) begin
    if (!rst) q.delete();
    else begin
      automatic int  sz = q.size();
      automatic bit  w  = wr_inc && sz < 8;
      automatic bit  r  = rd_inc && sz > 0;
      if (r) void'(q.pop_front());
      if (w) q.push_back(wr_data);
    end
  end
  always @(negedge clk) begin
    check("model_empty", {31'd0, rd_empty}, {31'd0, q.size() == 0});
    check("model_full", {31'd0, wr_full}, {31'd0, q.size() == 8});
    if (q.size() > 0) check("model_data", {24'd0, rd_data}, {24'd0, q[0]});
  end
  task automatic step(input logic wi, input logic ri, input logic [7:0] d);
    wr_inc = wi; rd_inc = ri; wr_data = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0; wr_inc = 1'b0; rd_inc = 1'b0; wr_data = 8'h00;
    #12;
    check("rst_empty", {31'd0, rd_empty}, 32'd1);
    check("rst_full", {31'd0, wr_full}, 32'd0);
    #10 rst = 1'b1;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("idle_empty", {31'd0, rd_empty}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i * 8'h11));
      check("fill_full", {31'd0, wr_full}, {31'd0, i == 8});
    end
    check("fill_empty", {31'd0, rd_empty}, 32'd0);
    step(1'b1, 1'b0, 8'h99);
    check("drop_full", {31'd0, wr_full}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", {24'd0, rd_data}, 32'(i * 8'h11));
      step(1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", {31'd0, rd_empty}, 32'd1);
    check("drain_full", {31'd0, wr_full}, 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("rd_when_empty", {31'd0, rd_empty}, 32'd1);
    step(1'b1, 1'b0, 8'hA5);
    check("a5_empty", {31'd0, rd_empty}, 32'd0);
    check("a5_data", {24'd0, rd_data}, 32'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("a5_drained", {31'd0, rd_empty}, 32'd1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 20; i++) begin
      check("rw_data", {24'd0, rd_data}, 32'(1 + i));
      step(1'b1, 1'b1, 8'(5 + i));
      check("rw_empty", {31'd0, rd_empty}, 32'd0);
      check("rw_full", {31'd0, wr_full}, 32'd0);
    end
    for (int i = 21; i <= 24; i++) begin
      check("rw_tail", {24'd0, rd_data}, 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end
    check("rw_tail_empty", {31'd0, rd_empty}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    check("full2", {31'd0, wr_full}, 32'd1);
    check("full2_head", {24'd0, rd_data}, 32'h30);
    step(1'b1, 1'b1, 8'hEE);
    check("full_rw_full", {31'd0, wr_full}, 32'd0);
    check("full_rw_head", {24'd0, rd_data}, 32'h31);
    for (int i = 1; i < 8; i++) begin
      check("full_rw_drain", {24'd0, rd_data}, 32'(8'h30 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    check("full_rw_empty", {31'd0, rd_empty}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    wr_inc = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_empty", {31'd0, rd_empty}, 32'd1);
    check("mid_rst_full", {31'd0, wr_full}, 32'd0);
    step(1'b1, 1'b0, 8'h77);
    check("rst_ignore_wr", {31'd0, rd_empty}, 32'd1);
    wr_inc = 1'b0;
    #2 rst = 1'b1;
    #1;
    step(1'b1, 1'b0, 8'h3C);
    check("post_rst_empty", {31'd0, rd_empty}, 32'd0);
    check("post_rst_data", {24'd0, rd_data}, 32'h3C);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_drain", {31'd0, rd_empty}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
